// File: rtl/spi_pkg.sv
// spi_pkg: shared width constants and mode type for the SPI slave
package spi_pkg;
    localparam int SPI_N = 8;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
    localparam int CNT_W = cnt_w(SPI_N);
    // only mode 0 (CPOL=0, CPHA=0) is implemented
    typedef enum logic [1:0] {SPI_MODE0, SPI_MODE1, SPI_MODE2, SPI_MODE3} spi_mode_e;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchronizer with a third copy for rise/fall pulse detection
module spi_sync #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic m, p;
    always_ff @(posedge clk) begin
        if (rst) {m, q, p} <= {3{IDLE}};
        else {m, q, p} <= {d, m, q};
    end
    assign rise = q & ~p;
    assign fall = ~q & p;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode 0 SPI slave, fixed N-bit frames; SPI_SLAVE_MISO_TRISTATE_EN floats miso when deselected
module spi_slave import spi_pkg::*; #(
    parameter int N = SPI_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mosi,
    input  logic         sclk,
    input  logic         ssbar,
    output logic         miso,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);
    localparam int CW = cnt_w(N);
    logic sclk_s, sclk_rise, sclk_fall;
    logic ss_s, ss_fall, ss_rise_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic [N-1:0] tx, rx;
    logic [CW-1:0] cnt;
    logic miso_r;
    spi_sync #(.IDLE(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync #(.IDLE(1'b1)) u_ss (.clk(clk), .rst(rst), .d(ssbar), .q(ss_s), .rise(ss_rise_unused), .fall(ss_fall));
    spi_sync #(.IDLE(1'b0)) u_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_r <= 1'b0;
            dout   <= '0;
            tx     <= '0;
            rx     <= '0;
            cnt    <= '0;
        end else if (ss_fall) begin
            tx     <= din;
            miso_r <= din[N-1];
            cnt    <= '0;
        end else if (ss_s) begin
            miso_r <= 1'b0;
        end else if (sclk_rise) begin
            rx  <= {rx[N-2:0], mosi_s};
            cnt <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
            if (cnt == CW'(N - 1)) dout <= {rx[N-2:0], mosi_s};
        end else if (sclk_fall) begin
            // a zero count means a word just completed: reload for back-to-back frames
            tx     <= (cnt == '0) ? din : {tx[N-2:0], 1'b0};
            miso_r <= (cnt == '0) ? din[N-1] : tx[N-2];
        end
    end
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign miso = ss_s ? 1'bz : miso_r;
`else
    assign miso = ss_s ? 1'b0 : miso_r;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master with a word-level model of dout and idle miso
module tb_spi_slave;
    localparam int HP = 10;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif
    logic clk = 1'b0, rst, mosi, sclk, ssbar, miso;
    logic [7:0] din, dout;
    int checks = 0, passes = 0;
    logic [7:0] exp_dout = 8'h00, m_word = 8'h00, pend = 8'h00;
    int m_bits = 0, pend_cnt = 0, ss_cnt = 0;
    bit run = 1'b0;
    logic [15:0] mi;

    spi_slave #(.N(8)) dut (.clk(clk), .rst(rst), .mosi(mosi), .sclk(sclk), .ssbar(ssbar), .miso(miso), .din(din), .dout(dout));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // received words appear on dout three clocks after the raw sclk rise
    always @(posedge clk) begin
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) exp_dout = pend;
        end
        ss_cnt = ssbar ? ss_cnt + 1 : 0;
    end

    always @(negedge clk) begin
        if (run) begin
            check("dout", {8'h00, dout}, {8'h00, exp_dout});
            if (ss_cnt >= 3) check("miso_idle", {15'h0, miso}, {15'h0, MISO_IDLE});
        end
    end

    task automatic frame(input logic [15:0] mo, input int nb, input int chg_at, input logic [7:0] chg_val, output logic [15:0] rx);
        rx = '0;
        ssbar = 1'b0;
        m_bits = 0;
        tick(5);
        for (int i = 0; i < nb; i++) begin
            mosi = mo[nb-1-i];
            tick(HP);
            rx = {rx[14:0], miso};
            sclk = 1'b1;
            m_word = {m_word[6:0], mosi};
            m_bits++;
            if (m_bits == 8) begin
                pend = m_word;
                pend_cnt = 3;
                m_bits = 0;
            end
            if (i + 1 == chg_at) din = chg_val;
            tick(HP);
            sclk = 1'b0;
        end
        tick(5);
        ssbar = 1'b1;
        tick(10);
    endtask

    initial begin
        rst = 1'b1; mosi = 1'b0; sclk = 1'b0; ssbar = 1'b1; din = 8'h00;
        tick(2);
        @(negedge clk);
        check("reset_miso", {15'h0, miso}, {15'h0, MISO_IDLE});
        check("reset_dout", {8'h00, dout}, 16'h0000);
        tick(1);
        rst = 1'b0;
        run = 1'b1;
        tick(5);
        din = 8'h01;
        frame(16'h0012, 8, -1, 8'h00, mi);
        check("f1_master_rx", mi, 16'h0001);
        check("f1_dout", {8'h00, dout}, 16'h0012);
        din = 8'h14;
        frame(16'h0037, 8, -1, 8'h00, mi);
        check("f2_master_rx", mi, 16'h0014);
        check("f2_dout", {8'h00, dout}, 16'h0037);
        din = 8'h5A;
        frame(16'h000A, 4, -1, 8'h00, mi);
        check("abort_dout", {8'h00, dout}, 16'h0037);
        check("abort_model", {8'h00, exp_dout}, 16'h0037);
        din = 8'h96;
        frame(16'h003C, 8, -1, 8'h00, mi);
        check("f3_master_rx", mi, 16'h0096);
        check("f3_dout", {8'h00, dout}, 16'h003C);
        din = 8'h81;
        frame(16'hF00F, 16, -1, 8'h00, mi);
        check("b2b_master_rx", mi, 16'h8181);
        check("b2b_dout", {8'h00, dout}, 16'h000F);
        din = 8'h55;
        frame(16'h00C3, 8, 3, 8'hAA, mi);
        check("dchg_master_rx", mi, 16'h0055);
        check("dchg_dout", {8'h00, dout}, 16'h00C3);
        tick(5);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
